ddr3_cmd_arbiter: RTL and testbench

- Shares the single DDR3 memory-controller command port between the AXI write path (store) and the AXI read path (fetch).
- Injects periodic refresh commands, which can be postponed under load.
- Sits between the AXI-to-DDR3 request bridge and the DDR3 FSM.
- Biases grants toward the current direction to reduce bus turnarounds, while bounding starvation.

---
 rtl/ddr3_cmd_arbiter.sv | 166 ++++++++++++++++
 tb/tb_ddr3_cmd_arbiter.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ddr3_cmd_arbiter.sv
// Arbitrates store/fetch/refresh onto the single DDR3 command port, biased to the current direction.
// Latency 1 cycle request-to-mem_req_o (1+TURN_CYC on a direction change); command held until mem_accept_i.
module ddr3_cmd_arbiter #(
  parameter int DDR_FREQ_MHZ = 100,
  parameter int DDR_ROW_BITS = 15,
  parameter int DDR_COL_BITS = 10,
  parameter int TREFI_NS     = 7800,
  parameter int REF_URGENT   = 4,
  parameter int MAX_RUN      = 4,
  parameter int TURN_CYC     = 2
) (
  input  logic                                 clock,
  input  logic                                 reset,
  input  logic                                 store_req_i,
  input  logic [DDR_ROW_BITS+DDR_COL_BITS-1:0] store_addr_i,
  output logic                                 store_gnt_o,
  input  logic                                 fetch_req_i,
  input  logic [DDR_ROW_BITS+DDR_COL_BITS-1:0] fetch_addr_i,
  output logic                                 fetch_gnt_o,
  output logic                                 mem_req_o,
  output logic [1:0]                           mem_cmd_o,
  output logic [DDR_ROW_BITS+DDR_COL_BITS-1:0] mem_addr_o,
  input  logic                                 mem_accept_i,
  output logic [3:0]                           ref_pend_o,
  output logic                                 ref_ovf_o
);

  localparam int AW       = DDR_ROW_BITS + DDR_COL_BITS;
  localparam int REFI_CYC = DDR_FREQ_MHZ * TREFI_NS / 1000;
  localparam int TW       = (REFI_CYC > 1) ? $clog2(REFI_CYC) : 1;
  localparam int RW       = $clog2(MAX_RUN + 1);

  localparam logic [1:0] CMD_NONE  = 2'b00;
  localparam logic [1:0] CMD_STORE = 2'b01;
  localparam logic [1:0] CMD_FETCH = 2'b10;
  localparam logic [1:0] CMD_REF   = 2'b11;

  typedef enum logic [1:0] {IDLE, TURN, ISSUE} state_t;

  state_t          state, state_nxt;
  logic [TW-1:0]   ref_timer;
  logic [3:0]      ref_pend;
  logic            ref_ovf;
  logic [7:0]      turn_cnt, turn_cnt_nxt;
  logic [1:0]      cmd_q, cmd_nxt;
  logic [AW-1:0]   addr_q, addr_nxt;
  logic            last_dir;
  logic [RW-1:0]   run;

  logic ref_wrap, issue, acc, acc_ref, acc_data, acc_dir;
  logic ref_urgent, data_req, run_full, pick_fetch;

  assign ref_wrap   = (ref_timer == TW'(REFI_CYC - 1));
  assign issue      = (state == ISSUE);
  assign acc        = issue && mem_accept_i;
  assign acc_ref    = acc && (cmd_q == CMD_REF);
  assign acc_data   = acc && (cmd_q != CMD_REF);
  assign acc_dir    = (cmd_q == CMD_FETCH);

  assign ref_urgent = (ref_pend >= 4'(REF_URGENT));
  assign data_req   = store_req_i || fetch_req_i;
  assign run_full   = (run >= RW'(MAX_RUN));
  // last_dir: 0 = store, 1 = fetch; with both waiting, flip only once the run is exhausted
  assign pick_fetch = (store_req_i && fetch_req_i) ? (last_dir ^ run_full) : fetch_req_i;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ref_timer <= '0;
    end else if (ref_wrap) begin
      ref_timer <= '0;
    end else begin
      ref_timer <= ref_timer + TW'(1);
    end
  end

  // A wrap and a refresh accept in the same cycle cancel out
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ref_pend <= 4'd0;
      ref_ovf  <= 1'b0;
    end else if (ref_wrap && !acc_ref) begin
      if (ref_pend == 4'd8) begin
        ref_ovf <= 1'b1;
      end else begin
        ref_pend <= ref_pend + 4'd1;
      end
    end else if (acc_ref && !ref_wrap) begin
      ref_pend <= ref_pend - 4'd1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      run      <= '0;
      last_dir <= 1'b0;
    end else if (acc_data) begin
      if (acc_dir == last_dir) begin
        run <= run_full ? run : run + RW'(1);
      end else begin
        run      <= RW'(1);
        last_dir <= acc_dir;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      turn_cnt <= 8'd0;
      cmd_q    <= CMD_NONE;
      addr_q   <= '0;
    end else begin
      state    <= state_nxt;
      turn_cnt <= turn_cnt_nxt;
      cmd_q    <= cmd_nxt;
      addr_q   <= addr_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    turn_cnt_nxt = turn_cnt;
    cmd_nxt      = cmd_q;
    addr_nxt     = addr_q;
    case (state)
      IDLE: begin
        if (ref_urgent || (!data_req && (ref_pend != 4'd0))) begin
          cmd_nxt   = CMD_REF;
          addr_nxt  = '0;
          state_nxt = ISSUE;
        end else if (data_req) begin
          cmd_nxt  = pick_fetch ? CMD_FETCH : CMD_STORE;
          addr_nxt = pick_fetch ? fetch_addr_i : store_addr_i;
          if ((pick_fetch != last_dir) && (TURN_CYC > 0)) begin
            turn_cnt_nxt = 8'(TURN_CYC - 1);
            state_nxt    = TURN;
          end else begin
            state_nxt = ISSUE;
          end
        end
      end
      TURN: begin
        if (turn_cnt == 8'd0) begin
          state_nxt = ISSUE;
        end else begin
          turn_cnt_nxt = turn_cnt - 8'd1;
        end
      end
      ISSUE: begin
        if (mem_accept_i) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign mem_req_o   = issue;
  assign mem_cmd_o   = issue ? cmd_q : CMD_NONE;
  assign mem_addr_o  = issue ? addr_q : '0;
  assign store_gnt_o = acc && (cmd_q == CMD_STORE);
  assign fetch_gnt_o = acc && (cmd_q == CMD_FETCH);
  assign ref_pend_o  = ref_pend;
  assign ref_ovf_o   = ref_ovf;

endmodule

// File: tb/tb_ddr3_cmd_arbiter.sv
// Directed phases plus a randomized phase, all checked every cycle against a transaction-level model.
module tb_ddr3_cmd_arbiter;
  localparam int AW     = 25;
  localparam int REFI   = 780;
  localparam int TURN   = 2;
  localparam int MAXRUN = 4;
  localparam int URG    = 4;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          store_req_i = 1'b0, fetch_req_i = 1'b0, mem_accept_i = 1'b0;
  logic [AW-1:0] store_addr_i = '0, fetch_addr_i = '0;
  logic          store_gnt_o, fetch_gnt_o, mem_req_o, ref_ovf_o;
  logic [1:0]    mem_cmd_o;
  logic [AW-1:0] mem_addr_o;
  logic [3:0]    ref_pend_o;

  always #5 clock = ~clock;

  ddr3_cmd_arbiter dut (
    .clock(clock), .reset(reset),
    .store_req_i(store_req_i), .store_addr_i(store_addr_i), .store_gnt_o(store_gnt_o),
    .fetch_req_i(fetch_req_i), .fetch_addr_i(fetch_addr_i), .fetch_gnt_o(fetch_gnt_o),
    .mem_req_o(mem_req_o), .mem_cmd_o(mem_cmd_o), .mem_addr_o(mem_addr_o),
    .mem_accept_i(mem_accept_i), .ref_pend_o(ref_pend_o), .ref_ovf_o(ref_ovf_o)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Model: one outstanding command, visible from cycle m_issue_at until accepted
  int            m_cyc, m_tick, m_pend, m_run, m_issue_at, last_wrap_cyc;
  bit            m_ovf, m_have, m_last;
  logic [1:0]    m_cmd;
  logic [AW-1:0] m_addr;
  bit            e_req, e_sg, e_fg;
  logic [1:0]    e_cmd;
  logic [AW-1:0] e_addr;

  // Requester/acceptor behaviour: 0 off, 1 hold continuously, 2 random, 3 one-shot
  int s_mode, f_mode, a_mode;
  logic [1:0] acc_log[$];
  int         ref_gaps[$];
  int         sg_count;
  bit         prev_req;

  task automatic model_reset();
    m_cyc = 0; m_tick = 0; m_pend = 0; m_run = 0; m_issue_at = 0;
    m_ovf = 0; m_have = 0; m_last = 0; m_cmd = 2'b00; m_addr = '0;
    e_req = 0; e_sg = 0; e_fg = 0; last_wrap_cyc = -1000; prev_req = 0;
  endtask

  task automatic model_eval();
    e_req  = m_have && (m_cyc >= m_issue_at);
    e_cmd  = e_req ? m_cmd : 2'b00;
    e_addr = e_req ? m_addr : '0;
    e_sg   = e_req && mem_accept_i && (m_cmd == 2'b01);
    e_fg   = e_req && mem_accept_i && (m_cmd == 2'b10);
  endtask

  task automatic model_step();
    bit wrap, acc_ref, want_fetch;
    wrap    = (m_tick == REFI - 1);
    acc_ref = e_req && mem_accept_i && (m_cmd == 2'b11);
    if (wrap) last_wrap_cyc = m_cyc;
    if (!m_have) begin
      if ((m_pend >= URG) || (!store_req_i && !fetch_req_i && m_pend > 0)) begin
        m_have = 1; m_cmd = 2'b11; m_addr = '0; m_issue_at = m_cyc + 1;
      end else if (store_req_i || fetch_req_i) begin
        if (store_req_i && fetch_req_i) want_fetch = (m_run >= MAXRUN) ? !m_last : m_last;
        else want_fetch = fetch_req_i;
        m_have = 1;
        m_cmd  = want_fetch ? 2'b10 : 2'b01;
        m_addr = want_fetch ? fetch_addr_i : store_addr_i;
        m_issue_at = m_cyc + 1 + ((want_fetch != m_last) ? TURN : 0);
      end
    end else if (e_req && mem_accept_i) begin
      if (m_cmd != 2'b11) begin
        if ((m_cmd == 2'b10) == m_last) m_run = (m_run < MAXRUN) ? m_run + 1 : MAXRUN;
        else begin m_run = 1; m_last = (m_cmd == 2'b10); end
      end
      m_have = 0;
    end
    if (wrap && !acc_ref) begin
      if (m_pend == 8) m_ovf = 1; else m_pend++;
    end else if (acc_ref && !wrap) begin
      m_pend--;
    end
    m_tick = (m_tick + 1) % REFI;
    m_cyc++;
  endtask

  task automatic drive_inputs();
    if (e_sg || !store_req_i) begin
      case (s_mode)
        1: begin store_req_i = 1'b1; store_addr_i = AW'($urandom); end
        2: begin store_req_i = ($urandom_range(0, 2) == 0); store_addr_i = AW'($urandom); end
        default: store_req_i = 1'b0;
      endcase
    end
    if (e_fg || !fetch_req_i) begin
      case (f_mode)
        1: begin fetch_req_i = 1'b1; fetch_addr_i = AW'($urandom); end
        2: begin fetch_req_i = ($urandom_range(0, 2) == 0); fetch_addr_i = AW'($urandom); end
        default: fetch_req_i = 1'b0;
      endcase
    end
    case (a_mode)
      0: mem_accept_i = 1'b0;
      1: mem_accept_i = 1'b1;
      default: mem_accept_i = 1'($urandom_range(0, 1));
    endcase
  endtask

  task automatic cycle();
    @(negedge clock);
    model_eval();
    chk("mem_req", mem_req_o, e_req);
    chk("mem_cmd", mem_cmd_o, e_cmd);
    chk("mem_addr", mem_addr_o, e_addr);
    chk("store_gnt", store_gnt_o, e_sg);
    chk("fetch_gnt", fetch_gnt_o, e_fg);
    chk("ref_pend", ref_pend_o, m_pend);
    chk("ref_ovf", ref_ovf_o, m_ovf);
    if (e_req && mem_accept_i) acc_log.push_back(e_cmd);
    if (store_gnt_o) sg_count++;
    if (mem_req_o && (mem_cmd_o == 2'b11) && !prev_req) ref_gaps.push_back(m_cyc - last_wrap_cyc);
    prev_req = mem_req_o;
    model_step();
    @(posedge clock);
    #1;
    drive_inputs();
  endtask

  task automatic run_cycles(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic do_reset();
    reset = 1'b0;
    #1;
    chk("rst_req", mem_req_o, 1'b0);
    chk("rst_cmd", mem_cmd_o, 2'b00);
    chk("rst_addr", mem_addr_o, '0);
    chk("rst_gnt", {store_gnt_o, fetch_gnt_o}, 2'b00);
    chk("rst_pend", ref_pend_o, 4'd0);
    chk("rst_ovf", ref_ovf_o, 1'b0);
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b1;
    model_reset();
    acc_log.delete();
    ref_gaps.delete();
    sg_count = 0;
  endtask

  initial begin
    // Single store from reset: last direction is store, so no turnaround
    s_mode = 3; f_mode = 0; a_mode = 1;
    store_req_i = 1'b1; store_addr_i = AW'(25'h0123); mem_accept_i = 1'b1;
    do_reset();
    run_cycles(6);
    chk("p1_ncmd", acc_log.size(), 1);
    chk("p1_cmd", acc_log[0], 2'b01);
    chk("p1_sgnt_cnt", sg_count, 1);

    // Both held: four grants per direction, then a turnaround
    s_mode = 1; f_mode = 1; a_mode = 1;
    store_req_i = 1'b1; fetch_req_i = 1'b1;
    do_reset();
    run_cycles(60);
    chk("p2_len_ok", acc_log.size() >= 12, 1'b1);
    for (int k = 0; k < 12; k++)
      chk($sformatf("p2_seq%0d", k), acc_log[k], ((k / 4) % 2 == 0) ? 2'b01 : 2'b10);

    // Idle traffic: one refresh per interval, issued shortly after each wrap
    s_mode = 0; f_mode = 0; a_mode = 1;
    store_req_i = 1'b0; fetch_req_i = 1'b0;
    do_reset();
    run_cycles(REFI * 3 + 5);
    chk("p3_nref", acc_log.size(), 3);
    foreach (acc_log[k]) chk($sformatf("p3_cmd%0d", k), acc_log[k], 2'b11);
    foreach (ref_gaps[k]) chk($sformatf("p3_gap%0d", k), ref_gaps[k] <= 2, 1'b1);
    chk("p3_pend", ref_pend_o, 4'd0);

    // Fetch stuck for four intervals: refresh becomes urgent
    s_mode = 0; f_mode = 1; a_mode = 0;
    fetch_req_i = 1'b1; fetch_addr_i = AW'($urandom); mem_accept_i = 1'b0;
    do_reset();
    run_cycles(REFI * 4 + 2);
    chk("p4_pend4", ref_pend_o, 4'd4);
    a_mode = 1; mem_accept_i = 1'b1;
    acc_log.delete();
    run_cycles(20);
    chk("p4_first_fetch", acc_log[0], 2'b10);
    chk("p4_then_ref", acc_log[1], 2'b11);

    // Nothing accepted for nine intervals: debt saturates and overflow sticks
    s_mode = 0; f_mode = 0; a_mode = 0;
    fetch_req_i = 1'b0; mem_accept_i = 1'b0;
    do_reset();
    run_cycles(REFI * 9 + 2);
    chk("p5_pend8", ref_pend_o, 4'd8);
    chk("p5_ovf", ref_ovf_o, 1'b1);
    run_cycles(100);
    chk("p5_pend_hold", ref_pend_o, 4'd8);
    chk("p5_ovf_hold", ref_ovf_o, 1'b1);
    do_reset();

    // Reset while a fetch is being presented; it is reissued afterwards
    s_mode = 0; f_mode = 3; a_mode = 0;
    fetch_req_i = 1'b1; fetch_addr_i = AW'($urandom); mem_accept_i = 1'b0;
    do_reset();
    run_cycles(5);
    chk("p6_pre_req", mem_req_o, 1'b1);
    chk("p6_pre_cmd", mem_cmd_o, 2'b10);
    do_reset();
    a_mode = 1; mem_accept_i = 1'b1;
    run_cycles(8);
    chk("p6_reissued", acc_log.size(), 1);
    chk("p6_reissue_cmd", acc_log[0], 2'b10);

    // Randomized traffic and acceptance
    s_mode = 2; f_mode = 2; a_mode = 2;
    store_req_i = 1'b0; fetch_req_i = 1'b0;
    do_reset();
    run_cycles(4000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
